ring_rr_arbiter: RTL and testbench
==================================

// Module: ring_rr_arbiter
// PURPOSE
//  Round-robin arbiter sharing one resource among N requesters, using a one-hot rotating
//  priority pointer (right-rotating ring, reset token at MSB). Grants one requester at a
//  time, holds the grant until the grantee signals done, then advances priority past the
//  winner. Sits between client blocks and the shared datapath on the single system clock.
// PARAMETERS
//  N         8   number of requesters (2..16)
//  HOLD_MAX  16  max cycles a grant may be held; used only when RING_ARB_TIMEOUT_EN is defined
//  IDXW      localparam = $clog2(N); width of gnt_idx
// PORTS
//  clk      in   1     system clock, all state on rising edge
//  rst_n    in   1     asynchronous, active-low reset
//  req      in   N     request per client; level, held until granted and served
//  done     in   1     single-cycle pulse from current grantee: transfer finished
//  gnt      out  N     one-hot grant, registered; all-zero when idle
//  gnt_idx  out  IDXW  binary index of granted client; valid only while busy=1
//  busy     out  1     1 while a grant is active
//  ptr      out  N     one-hot priority pointer (highest-priority position), debug/status
//  timeout  out  1     1-cycle pulse on forced release; constant 0 without the macro
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE, gnt=0, gnt_idx=0, busy=0, timeout=0,
//   ptr={1'b1,{N-1{1'b0}}} (MSB). Reset mid-grant drops the grant immediately.
//  Priority order: start at ptr bit position k, then k-1, k-2 ... wrapping N-1 after 0.
//  FSM states: IDLE, BUSY, GAP.
//   IDLE: if |req, pick first set bit in priority order; next edge gnt<=onehot(win),
//    gnt_idx<=win, busy<=1, go BUSY. Latency req->gnt = 1 cycle. If req==0 stay IDLE.
//   BUSY: grant frozen; req changes of other clients ignored. Release when done=1 OR
//    req[gnt_idx]=0 (client withdrew). On release edge: gnt<=0, busy<=0,
//    ptr<=rotate-right(onehot(win)) (winner becomes lowest priority), go GAP.
//   GAP: exactly one idle turnaround cycle, then IDLE. Minimum grant-to-grant spacing:
//    grant cycles + 2.
//  done while IDLE/GAP: ignored. done and req[gnt_idx] drop in same cycle: single release.
//  ptr updates only on release; never while IDLE with no requests.
//  All-requesters-asserted: each client served exactly once per N grants, in order
//   k, k-1, ... with wrap.
//  gnt is always zero or one-hot; never two bits set.
// CONFIGURATION
//  RING_ARB_TIMEOUT_EN defined: IDXW-independent counter (width $clog2(HOLD_MAX+1))
//   clears on BUSY entry, increments each BUSY cycle; when it reaches HOLD_MAX with no
//   release, forced release exactly as done, timeout=1 for that release cycle only.
//   Counter reset value 0.
//  Not defined: no counter, grant held indefinitely until done/withdraw, timeout tied 0.
// STRUCTURE
//  Package ring_arb_pkg: state encodings (IDLE=2'd0, BUSY=2'd1, GAP=2'd2), function
//   onehot2idx, function rotr1 (one-place right rotate of N-bit vector).
//  One sub-module: ring_rr_pick — combinational priority search (req, ptr -> win one-hot,
//   win_idx, any). Top holds FSM, ptr register, grant registers, optional timer.
// TESTING
//  1 Reset: rst_n=0 mid-BUSY (gnt=8'h04) -> gnt=0, busy=0, ptr=8'h80 immediately, no clk.
//  2 req=8'hFF held, done pulsed 1 cycle after each grant -> grant order idx 7,6,5,...,0,7;
//    ptr after first release = 8'h40; gnt never multi-hot.
//  3 req=8'h01 from IDLE, ptr=8'h80 -> gnt=8'h01 next edge, gnt_idx=0; wrap search works.
//  4 Grantee idx3 drops req with no done -> release next edge, ptr=8'h04, one GAP cycle.
//  5 done asserted while IDLE, req=0 -> no state change, ptr unchanged, busy stays 0.
//  6 With RING_ARB_TIMEOUT_EN, HOLD_MAX=16, no done -> timeout=1 on 16th BUSY cycle, gnt=0
//    next edge; without macro, same stimulus holds grant 100 cycles, timeout stays 0.

Source files
------------

// File: rtl/ring_arb_pkg.sv
// Shared state encodings and ring helpers for the round-robin arbiter.
// Helpers operate on a 16-bit container; callers zero-extend and slice to N bits.
package ring_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      GAP  = 2'd2
   } arb_state_e;

   localparam int MAX_N = 16;

   function automatic logic [3:0] onehot2idx(input logic [MAX_N-1:0] v);
      logic [3:0] idx;
      idx = '0;
      for (int i = 0; i < MAX_N; i++) begin
         if (v[i]) idx = idx | 4'(i);
      end
      return idx;
   endfunction

   // Rotates only the low n bits; bit 0 wraps into bit n-1.
   function automatic logic [MAX_N-1:0] rotr1(input logic [MAX_N-1:0] v, input int n);
      logic [MAX_N-1:0] r;
      r = '0;
      for (int i = 0; i < MAX_N; i++) begin
         if (i < n) r[4'(i)] = v[4'((i + 1) % n)];
      end
      return r;
   endfunction

endpackage

// File: rtl/ring_rr_pick.sv
// Combinational priority search: starting at the pointer position and walking
// downwards with wrap, returns the first requesting client.
module ring_rr_pick #(
   parameter int N    = 8,
   parameter int IDXW = $clog2(N)
) (
   input  logic [N-1:0]    req,
   input  logic [N-1:0]    ptr,
   output logic [N-1:0]    win,
   output logic [IDXW-1:0] win_idx,
   output logic            any
);
   import ring_arb_pkg::*;

   logic [3:0]      ptr_idx;
   logic [IDXW-1:0] pos;

   always_comb begin
      ptr_idx = onehot2idx(MAX_N'(ptr));
      win     = '0;
      win_idx = '0;
      any     = 1'b0;
      pos     = '0;
      for (int i = 0; i < N; i++) begin
         pos = IDXW'((int'(ptr_idx) + N - i) % N);
         if (!any && req[pos]) begin
            any      = 1'b1;
            win[pos] = 1'b1;
            win_idx  = pos;
         end
      end
   end

endmodule

// File: rtl/ring_rr_arbiter.sv
// Round-robin arbiter with a right-rotating one-hot priority ring and one gap cycle
// between grants. Define RING_ARB_TIMEOUT_EN to force release after HOLD_MAX busy cycles.
module ring_rr_arbiter #(
   parameter  int N        = 8,
   parameter  int HOLD_MAX = 16,
   localparam int IDXW     = $clog2(N)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N-1:0]    req,
   input  logic            done,
   output logic [N-1:0]    gnt,
   output logic [IDXW-1:0] gnt_idx,
   output logic            busy,
   output logic [N-1:0]    ptr,
   output logic            timeout
);
   import ring_arb_pkg::*;

   if (N < 2 || N > MAX_N || HOLD_MAX < 1) begin : g_bad_param
      $error("ring_rr_arbiter: N must be 2..16 and HOLD_MAX at least 1");
   end

   arb_state_e      state_q, state_d;
   logic [N-1:0]    gnt_q, gnt_d;
   logic [N-1:0]    ptr_q, ptr_d;
   logic [IDXW-1:0] gnt_idx_q, gnt_idx_d;
   logic [N-1:0]    win;
   logic [IDXW-1:0] win_idx;
   logic            any;
   logic            force_rel;
   logic [MAX_N-1:0] rot_ring;

   ring_rr_pick #(.N(N), .IDXW(IDXW)) u_pick (
      .req     (req),
      .ptr     (ptr_q),
      .win     (win),
      .win_idx (win_idx),
      .any     (any)
   );

`ifdef RING_ARB_TIMEOUT_EN
   localparam int CNTW = $clog2(HOLD_MAX + 1);
   logic [CNTW-1:0] cnt_q, cnt_d;

   // Counter sits at zero outside BUSY, so it is already cleared on entry.
   always_comb begin
      cnt_d = '0;
      if (state_q == BUSY) cnt_d = CNTW'(cnt_q + 1'b1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign force_rel = (state_q == BUSY) && (cnt_q == CNTW'(HOLD_MAX - 1))
                      && !done && req[gnt_idx_q];
   assign timeout   = force_rel;
`else
   assign force_rel = 1'b0;
   assign timeout   = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      gnt_idx_d = gnt_idx_q;
      ptr_d     = ptr_q;
      rot_ring  = rotr1(MAX_N'(gnt_q), N);
      case (state_q)
         IDLE: begin
            if (any) begin
               gnt_d     = win;
               gnt_idx_d = win_idx;
               state_d   = BUSY;
            end
         end
         BUSY: begin
            // Winner drops to lowest priority: its right neighbour leads next round.
            if (done || !req[gnt_idx_q] || force_rel) begin
               gnt_d   = '0;
               ptr_d   = rot_ring[N-1:0];
               state_d = GAP;
            end
         end
         GAP:     state_d = IDLE;
         default: begin
            state_d = IDLE;
            gnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         gnt_q     <= '0;
         gnt_idx_q <= '0;
         ptr_q     <= {1'b1, {(N-1){1'b0}}};
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         gnt_idx_q <= gnt_idx_d;
         ptr_q     <= ptr_d;
      end
   end

   assign gnt     = gnt_q;
   assign gnt_idx = gnt_idx_q;
   assign busy    = (state_q == BUSY);
   assign ptr     = ptr_q;

endmodule

// File: tb/tb_ring_rr_arbiter.sv
// Bench for ring_rr_arbiter: integer-level arbitration model checked every cycle,
// directed literal scenarios, then randomized request/done traffic.
`timescale 1ns/1ps
module tb_ring_rr_arbiter;
   localparam int N        = 8;
   localparam int HOLD_MAX = 16;
   localparam int IDXW     = 3;
`ifdef RING_ARB_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [N-1:0]    req = '0;
   logic            done = 1'b0;
   logic [N-1:0]    gnt;
   logic [IDXW-1:0] gnt_idx;
   logic            busy;
   logic [N-1:0]    ptr;
   logic            timeout;

   ring_rr_arbiter #(.N(N), .HOLD_MAX(HOLD_MAX)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .done(done),
      .gnt(gnt), .gnt_idx(gnt_idx), .busy(busy), .ptr(ptr), .timeout(timeout)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: priority position, current owner (-1 when none), gap flag, busy cycle count.
   int m_ptr   = N - 1;
   int m_owner = -1;
   int m_cyc   = 0;
   bit m_gap   = 1'b0;

   function automatic int pick_winner(input logic [N-1:0] r, input int k);
      for (int i = 0; i < N; i++) begin
         if (r[(k - i + N) % N]) return (k - i + N) % N;
      end
      return -1;
   endfunction

   function automatic bit model_release();
      return done || !req[m_owner] || (TO_EN && m_cyc == HOLD_MAX);
   endfunction

   function automatic bit exp_timeout();
      if (m_owner < 0) return 1'b0;
      return TO_EN && m_cyc == HOLD_MAX && !done && req[m_owner];
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_ptr   <= N - 1;
         m_owner <= -1;
         m_cyc   <= 0;
         m_gap   <= 1'b0;
      end else if (m_owner >= 0) begin
         if (model_release()) begin
            m_ptr   <= (m_owner + N - 1) % N;
            m_owner <= -1;
            m_gap   <= 1'b1;
         end else begin
            m_cyc <= m_cyc + 1;
         end
      end else if (m_gap) begin
         m_gap <= 1'b0;
      end else if (req != '0) begin
         m_owner <= pick_winner(req, m_ptr);
         m_cyc   <= 1;
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         check("gnt",     32'(gnt),     (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
         check("busy",    32'(busy),    32'(m_owner >= 0));
         check("ptr",     32'(ptr),     32'd1 << m_ptr);
         check("timeout", 32'(timeout), 32'(exp_timeout()));
         check("onehot",  32'($countones(gnt) <= 1), 32'd1);
         if (m_owner >= 0) check("gnt_idx", 32'(gnt_idx), 32'(m_owner));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_busy(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (busy) begin
            ok = 1'b1;
            return;
         end
         tick();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit ok;
      bit to_seen;

      // Reset values
      tick();
      check("rst_gnt",     32'(gnt),     32'h00);
      check("rst_busy",    32'(busy),    32'd0);
      check("rst_ptr",     32'(ptr),     32'h80);
      check("rst_gnt_idx", 32'(gnt_idx), 32'd0);
      check("rst_timeout", 32'(timeout), 32'd0);
      tick();
      rst_n = 1'b1;

      // Lowest client wins from pointer at MSB (wrap search)
      req = 8'h01;
      tick();
      check("wrap_gnt",     32'(gnt),     32'h01);
      check("wrap_gnt_idx", 32'(gnt_idx), 32'd0);
      check("wrap_busy",    32'(busy),    32'd1);
      done = 1'b1;
      tick();
      done = 1'b0;
      req  = 8'h00;
      check("wrap_release", 32'(gnt), 32'h00);
      check("wrap_ptr",     32'(ptr), 32'h80);
      tick();

      // done while idle with no requests
      tick();
      done = 1'b1;
      tick();
      done = 1'b0;
      check("idle_done_busy", 32'(busy), 32'd0);
      check("idle_done_ptr",  32'(ptr),  32'h80);
      tick();
      check("idle_done_busy2", 32'(busy), 32'd0);

      // Withdraw without done, then the one-cycle gap
      req = 8'h08;
      tick();
      check("wd_gnt", 32'(gnt), 32'h08);
      req = 8'h00;
      tick();
      check("wd_release", 32'(gnt),  32'h00);
      check("wd_busy",    32'(busy), 32'd0);
      check("wd_ptr",     32'(ptr),  32'h04);
      req = 8'h08;
      tick();
      check("gap_busy", 32'(busy), 32'd0);
      tick();
      check("gap_regrant", 32'(gnt), 32'h08);
      done = 1'b1;
      req  = 8'h00;
      tick();
      done = 1'b0;
      check("both_release", 32'(busy), 32'd0);
      check("both_ptr",     32'(ptr),  32'h04);
      tick();

      // Asynchronous reset in the middle of a grant
      req = 8'h04;
      tick();
      check("pre_rst_gnt", 32'(gnt), 32'h04);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_gnt",  32'(gnt),  32'h00);
      check("async_rst_busy", 32'(busy), 32'd0);
      check("async_rst_ptr",  32'(ptr),  32'h80);
      req = 8'h00;
      tick();
      tick();
      rst_n = 1'b1;

      // All clients requesting: order 7,6,...,0,7
      req = 8'hFF;
      for (int g = 0; g < 9; g++) begin
         wait_busy(ok);
         if (!ok) begin
            check("order_wait", 32'd0, 32'd1);
            break;
         end
         check("order_idx", 32'(gnt_idx), 32'((15 - g) % 8));
         done = 1'b1;
         tick();
         done = 1'b0;
         if (g == 0) check("order_ptr1", 32'(ptr), 32'h40);
      end
      req = 8'h00;
      repeat (3) tick();

      // Long hold without done
      req = 8'h10;
      wait_busy(ok);
      check("hold_wait", 32'(ok), 32'd1);
      check("hold_gnt",  32'(gnt), 32'h10);
`ifdef RING_ARB_TIMEOUT_EN
      to_seen = 1'b0;
      repeat (HOLD_MAX - 1) begin
         if (timeout) to_seen = 1'b1;
         tick();
      end
      check("to_early",    32'(to_seen), 32'd0);
      check("to_pulse",    32'(timeout), 32'd1);
      check("to_gnt_held", 32'(gnt),     32'h10);
      tick();
      check("to_release", 32'(gnt),     32'h00);
      check("to_clear",   32'(timeout), 32'd0);
`else
      to_seen = 1'b0;
      repeat (100) begin
         tick();
         if (timeout) to_seen = 1'b1;
      end
      check("hold_timeout", 32'(to_seen), 32'd0);
      check("hold_gnt100",  32'(gnt),     32'h10);
      check("hold_busy100", 32'(busy),    32'd1);
      done = 1'b1;
      tick();
      done = 1'b0;
`endif
      req = 8'h00;
      repeat (3) tick();

      // Randomized traffic against the model
      repeat (3000) begin
         if ($urandom_range(3) == 0) begin
            req = 8'($urandom_range(255));
            if ($urandom_range(1) == 1) req = req & 8'($urandom_range(255));
         end
         done = ($urandom_range(5) == 0);
         tick();
      end
      done = 1'b0;
      req  = 8'h00;
      repeat (3) tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
